// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and multiply sequencer state type
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  // Iteration index at which a full-length multiply finishes
  localparam logic [5:0] MUL_LAST_ITER = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - operand/result handshake bundle for the multiply sequencer
interface alu_mul_seq_if #(
  parameter int WIDTH = 64
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic             zero;
  logic             busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product, ovf, zero, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product, ovf, zero, busy
  );

endinterface

// File: rtl/alu_mul_seq_alu.sv
// rtl/alu_mul_seq_alu.sv - shared 64-bit combinational ALU
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       cntrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             overflow_o
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // Subtraction is a + ~b + 1, so carry_out means "no borrow"
  assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_ext = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  // Operation select and flag generation
  always_comb begin
    result_o    = '0;
    carry_out_o = 1'b0;
    overflow_o  = 1'b0;
    case (cntrl_i)
      ALU_PASS_B: result_o = b_i;
      ALU_ADD: begin
        result_o    = sum_ext[WIDTH-1:0];
        carry_out_o = sum_ext[WIDTH];
        overflow_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o    = diff_ext[WIDTH-1:0];
        carry_out_o = diff_ext[WIDTH];
        overflow_o  = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
    zero_o     = (result_o == '0);
    negative_o = result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 64x64 multiply sequencer (option: MUL_EARLY_EXIT_EN)
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);

  mul_state_e       state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [5:0]       cnt_q,    cnt_d;
  logic             lost_q,   lost_d;
  logic             ovf_r_q,  ovf_r_d;
  logic [WIDTH-1:0] prod_q,   prod_d;
  logic             fovf_q,   fovf_d;
  logic             fzero_q,  fzero_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero_unused;
  logic             alu_neg_unused;
  logic             alu_ovf_unused;
  logic             run_exit;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i         (acc_q),
    .b_i         (mcand_q),
    .cntrl_i     (ALU_ADD),
    .result_o    (alu_result),
    .carry_out_o (alu_carry),
    .zero_o      (alu_zero_unused),
    .negative_o  (alu_neg_unused),
    .overflow_o  (alu_ovf_unused)
  );

  // Next-state, iteration datapath and result capture
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    lost_d   = lost_q;
    ovf_r_d  = ovf_r_q;
    prod_d   = prod_q;
    fovf_d   = fovf_q;
    fzero_d  = fzero_q;
    run_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_d  = ST_RUN;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          lost_d   = 1'b0;
          ovf_r_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // lost_q covers bits already shifted out of mcand before this step
        if (mplier_q[0]) begin
          acc_d   = alu_result;
          ovf_r_d = ovf_r_q | alu_carry | lost_q;
        end
        lost_d   = lost_q | mcand_q[WIDTH-1];
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 6'd1;
`ifdef MUL_EARLY_EXIT_EN
        // No multiplier bits left: further iterations cannot change acc or ovf
        run_exit = (cnt_q == MUL_LAST_ITER) || (mplier_d == '0);
`else
        run_exit = (cnt_q == MUL_LAST_ITER);
`endif
        if (run_exit) begin
          state_d = ST_DONE;
          prod_d  = acc_d;
          fovf_d  = ovf_r_d;
          fzero_d = (acc_d == '0);
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          prod_d  = '0;
          fovf_d  = 1'b0;
          fzero_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      ovf_r_q  <= 1'b0;
      prod_q   <= '0;
      fovf_q   <= 1'b0;
      fzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      ovf_r_q  <= ovf_r_d;
      prod_q   <= prod_d;
      fovf_q   <= fovf_d;
      fzero_q  <= fzero_d;
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.res_valid   = (state_q == ST_DONE);
  assign bus.product     = prod_q;
  assign bus.ovf         = fovf_q;
  assign bus.zero        = fzero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq
module tb_alu_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(64)) bus();

  alu_mul_seq #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < 64; i++) if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
`else
    return 64;
`endif
  endfunction

  function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] p, output logic o, output logic z);
    logic [127:0] full;
    full = {64'b0, a} * {64'b0, b};
    p = full[63:0];
    o = (full[127:64] != 0);
    z = (full[63:0] == 0);
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] p, output logic o, output logic z, output int lat);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.product;
    o = bus.ovf;
    z = bus.zero;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ep, input logic eo, input logic ez);
    logic [63:0] p;
    logic o, z;
    int lat;
    run_op(a, b, p, o, z, lat);
    chk({name, ".product"}, p, ep);
    chk({name, ".ovf"}, 64'(o), 64'(eo));
    chk({name, ".zero"}, 64'(z), 64'(ez));
    chk({name, ".latency"}, 64'(lat), 64'(exp_latency(b)));
    chk({name, ".ready_after"}, 64'(bus.start_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb, ep;
    logic eo, ez;
    int lat;

    vecs[0] = '{64'd3, 64'd5, 64'd15, 1'b0, 1'b0};
    vecs[1] = '{64'h1234, 64'd0, 64'd0, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0};
    vecs[4] = '{64'h1_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0};
    vecs[5] = '{64'd7, 64'd9, 64'd63, 1'b0, 1'b0};

    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.start_ready", 64'(bus.start_ready), 64'd1);
    chk("rst.res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst.product", bus.product, 64'd0);
    chk("rst.ovf", 64'(bus.ovf), 64'd0);
    chk("rst.zero", 64'(bus.zero), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].ovf, vecs[i].zero);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      ra = ra >> $urandom_range(0, 63);
      rb = rb >> $urandom_range(0, 63);
      if (i % 6 == 5) rb = '0;
      ref_mul(ra, rb, ep, eo, ez);
      check_op($sformatf("rnd%0d", i), ra, rb, ep, eo, ez);
    end

    // Back-pressure: result held while new operands wait
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a = 64'd3;
    bus.b = 64'd5;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.res_valid", 64'(bus.res_valid), 64'd1);
    bus.start_valid = 1'b1;
    bus.a = 64'd99;
    bus.b = 64'd99;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.product", c), bus.product, 64'd15);
      chk($sformatf("bp.hold%0d.res_valid", c), 64'(bus.res_valid), 64'd1);
      chk($sformatf("bp.hold%0d.flags", c), {62'd0, bus.ovf, bus.zero}, 64'd0);
      chk($sformatf("bp.hold%0d.start_ready", c), 64'(bus.start_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("bp.after_hs.res_valid", 64'(bus.res_valid), 64'd0);
    chk("bp.after_hs.start_ready", 64'(bus.start_ready), 64'd1);
    chk("bp.after_hs.busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    chk("bp.accept.busy", 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.second.product", bus.product, 64'd9801);
    chk("bp.second.latency", 64'(lat), 64'(exp_latency(64'd99)));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a = 64'd7;
    bus.b = 64'd9;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    chk("mr.busy_before", 64'(bus.busy), 64'(exp_latency(64'd9) > 20));
    rst_n = 1'b0;
    #1;
    chk("mr.start_ready", 64'(bus.start_ready), 64'd1);
    chk("mr.busy", 64'(bus.busy), 64'd0);
    chk("mr.res_valid", 64'(bus.res_valid), 64'd0);
    chk("mr.product", bus.product, 64'd0);
    chk("mr.flags", {62'd0, bus.ovf, bus.zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_op("mr.rerun", 64'd7, 64'd9, 64'd63, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
